// File: rtl/mux_scan_n_if.sv
// Channel bus for mux_scan_n: packed inputs, select/mode/enable in,
// registered data/channel/valid/wrap out. master drives, slave is the mux.
interface mux_scan_n_if #(
  parameter int N = 8,
  parameter int W = 4
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [SW-1:0]  in_sel;
  logic           in_mode;
  logic           in_en;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_wrap;

  modport master (
    output in_data, in_sel, in_mode, in_en,
    input  out_data, out_ch, out_valid, out_wrap
  );

  modport slave (
    input  in_data, in_sel, in_mode, in_en,
    output out_data, out_ch, out_valid, out_wrap
  );
endinterface

// File: rtl/mux_scan_n.sv
// N:1 W-bit mux with registered output; manual select or auto scan
// dwelling HOLD cycles per channel. Ports: clk, rst_n, bus (slave).
module mux_scan_n #(
  parameter int N    = 8,
  parameter int W    = 4,
  parameter int HOLD = 4
) (
  input logic         clk,
  input logic         rst_n,
  mux_scan_n_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [SW:0]   NUM    = (SW+1)'(N);
  localparam logic [SW-1:0] LAST   = SW'(N - 1);
  localparam logic [CW-1:0] CNTEND = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_t;

  logic [W-1:0]  ch [N];
  logic [SW-1:0] scanCh;
  logic [CW-1:0] cnt;
  state_t        state;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign ch[k] = bus.in_data[k*W +: W];
  end

  always_comb begin
    state = IDLE;
    unique case (1'b1)
      !bus.in_en:                 state = IDLE;
      bus.in_en && !bus.in_mode:  state = MANUAL;
      bus.in_en && bus.in_mode:   state = SCAN;
      default:                    state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_wrap  <= 1'b0;
      scanCh        <= '0;
      cnt           <= '0;
    end else begin
      bus.out_wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.out_valid <= 1'b0;
          cnt           <= '0;
        end
        MANUAL: begin
          cnt        <= '0;
          bus.out_ch <= bus.in_sel;
          // select codes beyond N-1 only exist when N is not 2^k
          if ({1'b0, bus.in_sel} < NUM) begin
            bus.out_data  <= ch[bus.in_sel];
            bus.out_valid <= 1'b1;
          end else begin
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
          end
        end
        SCAN: begin
          bus.out_data  <= ch[scanCh];
          bus.out_ch    <= scanCh;
          bus.out_valid <= 1'b1;
          if (cnt == CNTEND) begin
            cnt <= '0;
            if (scanCh == LAST) begin
              scanCh       <= '0;
              bus.out_wrap <= 1'b1;
            end else begin
              scanCh <= scanCh + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          cnt           <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: N=8/HOLD=4 instance and
// N=6/HOLD=1 instance sharing clock and reset.
module tb_mux_scan_n;
  logic clk = 1'b0;
  logic rst_n;
  int   nCmp = 0;
  int   nBad = 0;

  always #5 clk = ~clk;

  mux_scan_n_if #(.N(8), .W(4)) busA ();
  mux_scan_n_if #(.N(6), .W(4)) busB ();

  mux_scan_n #(.N(8), .W(4), .HOLD(4)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  mux_scan_n #(.N(6), .W(4), .HOLD(1)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chkA(input string tag, input int d, input int c,
                      input int v, input int w);
    check({tag, ".data"},  32'(busA.out_data),  d);
    check({tag, ".ch"},    32'(busA.out_ch),    c);
    check({tag, ".valid"}, 32'(busA.out_valid), v);
    check({tag, ".wrap"},  32'(busA.out_wrap),  w);
  endtask

  task automatic chkB(input string tag, input int d, input int c,
                      input int v, input int w);
    check({tag, ".data"},  32'(busB.out_data),  d);
    check({tag, ".ch"},    32'(busB.out_ch),    c);
    check({tag, ".valid"}, 32'(busB.out_valid), v);
    check({tag, ".wrap"},  32'(busB.out_wrap),  w);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    rst_n        = 1'b0;
    busA.in_data = 32'h8765_4321;
    busA.in_sel  = '0;
    busA.in_mode = 1'b0;
    busA.in_en   = 1'b0;
    busB.in_data = 24'h65_4321;
    busB.in_sel  = '0;
    busB.in_mode = 1'b0;
    busB.in_en   = 1'b0;

    tick;
    tick;
    chkA("rst", 0, 0, 0, 0);
    chkB("rstB", 0, 0, 0, 0);

    rst_n = 1'b1;
    tick;
    chkA("idle0", 0, 0, 0, 0);

    busA.in_en  = 1'b1;
    busA.in_sel = 3'd5;
    tick;
    chkA("man5", 6, 5, 1, 0);
    busA.in_sel = 3'd0;
    tick;
    chkA("man0", 1, 0, 1, 0);

    // async reset between edges
    #2 rst_n = 1'b0;
    #1 chkA("arst", 0, 0, 0, 0);
    busA.in_en = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chkA("relIdle", 0, 0, 0, 0);

    busA.in_mode = 1'b1;
    busA.in_en   = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      tick;
      e = (i / 4) % 8;
      chkA($sformatf("scan%0d", i), e + 1, e, 1, (i == 31) ? 1 : 0);
    end

    // fresh scan, leave at 2nd cycle of ch3
    #2 rst_n = 1'b0;
    busA.in_en = 1'b0;
    #2 rst_n = 1'b1;
    busA.in_en = 1'b1;
    for (int i = 0; i < 14; i++) tick;
    chkA("ch3b", 4, 3, 1, 0);
    busA.in_mode = 1'b0;
    busA.in_sel  = 3'd1;
    tick;
    chkA("swMan", 2, 1, 1, 0);
    busA.in_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      busA.in_data = (i == 2) ? 32'h8765_A321 : 32'h8765_4321;
      tick;
      chkA($sformatf("res3_%0d", i), (i == 2) ? 10 : 4, 3, 1, 0);
    end
    busA.in_data = 32'h8765_4321;
    tick;
    chkA("ch4a", 5, 4, 1, 0);
    tick;
    chkA("ch4b", 5, 4, 1, 0);

    busA.in_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chkA($sformatf("hold%0d", i), 5, 4, 0, 0);
    end
    busA.in_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chkA($sformatf("fresh4_%0d", i), 5, 4, 1, 0);
    end
    tick;
    chkA("ch5", 6, 5, 1, 0);
    busA.in_en = 1'b0;

    // N=6: out-of-range select, then HOLD=1 scan
    busB.in_en  = 1'b1;
    busB.in_sel = 3'd7;
    tick;
    chkB("bSel7", 0, 7, 0, 0);
    busB.in_sel = 3'd6;
    tick;
    chkB("bSel6", 0, 6, 0, 0);
    busB.in_sel = 3'd2;
    tick;
    chkB("bSel2", 3, 2, 1, 0);
    busB.in_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      e = i % 6;
      chkB($sformatf("bScan%0d", i), e + 1, e, 1, (i == 5) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
